// File: rtl/aemb_ibuf_dec.sv
// Fetch skid buffer + decode: fields valid 1 cycle after the chosen edge, IMM-prefix immediates, interrupt injection.
// Backpressure: gena=0 holds decode; one ack is parked in the skid and iwb_stb_o drops until it drains.
module aemb_ibuf_dec #(
  parameter int          ISYNC   = 2,
  parameter bit          IRQEDGE = 1'b1,
  parameter logic [31:0] NOPWORD = 32'h8000_0000
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        gena,
  input  logic [31:0] iwb_dat_i,
  input  logic        iwb_ack_i,
  output logic        iwb_stb_o,
  input  logic        sys_int_i,
  input  logic        rMSR_IE,
  input  logic        rDLY,
  input  logic        rBRA,
  output logic [5:0]  rOPC,
  output logic [4:0]  rRD,
  output logic [4:0]  rRA,
  output logic [4:0]  rRB,
  output logic [15:0] rIMM,
  output logic [10:0] rALT,
  output logic [31:0] rSIMM,
  output logic [1:0]  rXCE
);

  logic             r_skid_vld;
  logic [31:0]      r_skid_dat;
  logic             r_stb;
  logic [31:0]      r_inst;
  logic [31:0]      r_simm;
  logic [1:0]       r_xce;
  logic             r_imm_flg;
  logic [15:0]      r_immhi;
  logic [ISYNC-1:0] r_sync;
  logic             r_sync_d;
  logic             r_pend;

  logic             w_bubble;
  logic [31:0]      w_word;
  logic [31:0]      w_dec;
  logic [31:0]      w_simm;
  logic             w_sync;
  logic             w_rise;
  logic             w_pend;
  logic             w_take;
  logic             w_live;
  logic             w_skid_vld_nxt;
  logic [31:0]      w_skid_dat_nxt;

  always_comb begin
    w_bubble = !r_skid_vld && !iwb_ack_i;
    w_word   = r_skid_vld ? r_skid_dat : (iwb_ack_i ? iwb_dat_i : NOPWORD);
    w_sync   = r_sync[ISYNC-1];
    w_rise   = w_sync && !r_sync_d;
    // Edge mode sees a fresh rising edge in the same cycle it is detected
    w_pend   = IRQEDGE ? (r_pend || w_rise) : w_sync;
    w_take   = gena && w_pend && rMSR_IE && !r_imm_flg && !rDLY && !rBRA;
    w_live   = !w_bubble && !w_take;
    w_dec    = w_take ? NOPWORD : w_word;
    if (!w_live)
      w_simm = 32'h0;
    else if (r_imm_flg)
      w_simm = {r_immhi, w_word[15:0]};
    else
      w_simm = {{16{w_word[15]}}, w_word[15:0]};
  end

  always_comb begin
    w_skid_vld_nxt = r_skid_vld;
    w_skid_dat_nxt = r_skid_dat;
    if (gena) begin
      if (r_skid_vld && iwb_ack_i) begin
        w_skid_dat_nxt = iwb_dat_i;
      end else begin
        w_skid_vld_nxt = 1'b0;
      end
    end else if (iwb_ack_i && !r_skid_vld) begin
      w_skid_vld_nxt = 1'b1;
      w_skid_dat_nxt = iwb_dat_i;
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_skid_vld <= 1'b0;
      r_skid_dat <= 32'h0;
      r_stb      <= 1'b0;
      r_inst     <= NOPWORD;
      r_simm     <= 32'h0;
      r_xce      <= 2'o0;
      r_imm_flg  <= 1'b0;
      r_immhi    <= 16'h0;
      r_sync     <= '0;
      r_sync_d   <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_skid_vld <= w_skid_vld_nxt;
      r_skid_dat <= w_skid_dat_nxt;
      r_stb      <= !w_skid_vld_nxt;
      r_sync     <= {r_sync[ISYNC-2:0], sys_int_i};
      r_sync_d   <= w_sync;
      r_pend     <= IRQEDGE ? (w_pend && !w_take) : 1'b0;
      if (gena) begin
        r_inst <= w_dec;
        r_simm <= w_simm;
        r_xce  <= w_take ? 2'o2 : 2'o0;
        if (w_live) begin
          if (w_word[31:26] == 6'o54) begin
            r_imm_flg <= 1'b1;
            r_immhi   <= w_word[15:0];
          end else begin
            r_imm_flg <= 1'b0;
          end
        end
      end
    end
  end

  assign iwb_stb_o = r_stb;
  assign rOPC      = r_inst[31:26];
  assign rRD       = r_inst[25:21];
  assign rRA       = r_inst[20:16];
  assign rRB       = r_inst[15:11];
  assign rIMM      = r_inst[15:0];
  assign rALT      = r_inst[10:0];
  assign rSIMM     = r_simm;
  assign rXCE      = r_xce;

endmodule
